load_store_unit: RTL

//   Initiator side of the data-memory port. Accepts one load/store request at a

---
 rtl/load_store_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory port.
// Accepts one request at a time from the pipeline, performs a single
// store strobe or a (possibly multi-cycle) load, and returns a response
// held stable until the pipeline accepts it.
module load_store_unit #(
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_address,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             memory_write_enable,
    output logic [WIDTH-1:0] address_rw,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out,
    output logic             busy
);

    // Counter only needs to reach READ_LATENCY; keep at least one bit.
    localparam int CNT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             write_q;
    logic [WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0] cnt;

    // Next-state selection: a store spends one cycle in ACCESS, a load
    // stays until the wait counter reaches the read latency.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ACCESS;
            ACCESS:  if (write_q || cnt == LAST) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture, load wait counter and read-data sampling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_address;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                        rdata_q <= '0;
                        cnt     <= '0;
                    end
                end
                ACCESS: begin
                    if (!write_q) begin
                        if (cnt == LAST) begin
                            rdata_q <= data_out;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The write strobe is decoded from state so that it falls as soon as
    // reset is asserted, without waiting for a clock edge.
    assign memory_write_enable = (state == ACCESS) && write_q;
    assign req_ready           = (state == IDLE);
    assign rsp_valid           = (state == RESP);
    assign busy                = (state != IDLE);
    assign address_rw          = addr_q;
    assign data_in             = wdata_q;
    assign rsp_write           = write_q;
    assign rsp_rdata           = rdata_q;

endmodule
